// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: buffers packed {sel,B,A} commands, drives a combinational
//   3-bit arithmetic unit from registers and returns tagged results.
// Latency: push at edge n -> operands after n+1 -> out_valid after n+1+SETTLE.
// Backpressure: out_ready low holds the result in HOLD; the FIFO then fills
//   and in_ready drops once level reaches DEPTH.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  command handshake; in_cmd = [7:6] sel, [5:3] B, [2:0] A
//   alu_a/alu_b/alu_sel registered operands to the arithmetic unit
//   alu_result         combinational result returned by the unit
//   out_valid/out_ready result handshake; out_result/out_sel/out_dz payload
//   level              FIFO occupancy, head (command in flight) included
module alu_cmd_queue #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_cmd,
  output logic [2:0]               alu_a,
  output logic [2:0]               alu_b,
  output logic [1:0]               alu_sel,
  input  logic [5:0]               alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_result,
  output logic [1:0]               out_sel,
  output logic                     out_dz,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [7:0]      head;
  logic            push;
  logic            pop;
  logic            dz;

  // Readiness depends on level only, so a pop in the same cycle never
  // lets a push into a full FIFO.
  assign in_ready = !rst && (level < LW'(DEPTH));
  assign push     = in_valid && in_ready;
  // The head leaves the FIFO only when its result is captured.
  assign pop      = (state == S_SETTLE) && (cnt == LAST);
  assign head     = mem[rd_ptr];
  assign dz       = (alu_sel == 2'b11) && (alu_b == 3'd0);

  // Storage needs no reset: entries are only read while level > 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_sel    <= '0;
      out_dz     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase

      case (state)
        S_IDLE: begin
          if (level != '0) begin
            alu_a   <= head[2:0];
            alu_b   <= head[5:3];
            alu_sel <= head[7:6];
            cnt     <= '0;
            state   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt == LAST) begin
            // Divide by zero returns an all-ones marker instead of whatever
            // the unit happens to produce.
            out_result <= dz ? 6'h3F : alu_result;
            out_sel    <= alu_sel;
            out_dz     <= dz;
            out_valid  <= 1'b1;
            state      <= S_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // The held entry was already popped, so level is what remains.
            if (level != '0) begin
              alu_a   <= head[2:0];
              alu_b   <= head[5:3];
              alu_sel <= head[7:6];
              cnt     <= '0;
              state   <= S_SETTLE;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue (DEPTH=4, SETTLE=1) with a behavioural
// arithmetic unit hooked to the operand/result lines.
module tb_alu_cmd_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_cmd;
  logic [2:0] alu_a;
  logic [2:0] alu_b;
  logic [1:0] alu_sel;
  logic [5:0] alu_result;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_result;
  logic [1:0] out_sel;
  logic       out_dz;
  logic [2:0] level;

  int errors = 0;
  int checks = 0;
  int idx;
  int ridx;
  logic acc;

  // Fill/drain commands and hand-computed results.
  logic [7:0] fc [5] = '{8'h1D, 8'h6A, 8'hBF, 8'hD7, 8'hC6};
  logic [5:0] fr [5] = '{6'd8, 6'h3D, 6'd49, 6'd3, 6'h3F};
  logic [1:0] fs [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
  logic       fd [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  // Wrap-around commands and hand-computed results.
  logic [7:0] wc [8] = '{8'h09, 8'h4B, 8'hB5, 8'hDF, 8'h3F, 8'h78, 8'hC1, 8'hA6};
  logic [5:0] wr [8] = '{6'd2, 6'd2, 6'd30, 6'd2, 6'd14, 6'd57, 6'h3F, 6'd24};
  logic [1:0] ws [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2};

  alu_cmd_queue #(.DEPTH(4), .SETTLE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cmd     (in_cmd),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_sel    (out_sel),
    .out_dz     (out_dz),
    .level      (level)
  );

  always #5 clk = ~clk;

  // Arithmetic unit; divide by zero yields 0 so the queue must substitute.
  always_comb begin
    alu_result = 6'd0;
    case (alu_sel)
      2'd0: alu_result = {3'd0, alu_a} + {3'd0, alu_b};
      2'd1: alu_result = {3'd0, alu_a} - {3'd0, alu_b};
      2'd2: alu_result = {3'd0, alu_a} * {3'd0, alu_b};
      default: alu_result = (alu_b == 3'd0) ? 6'd0 : ({3'd0, alu_a} / {3'd0, alu_b});
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command through an idle queue with out_ready high.
  task automatic single(input string tag, input logic [7:0] cmd, input logic [5:0] er,
                        input logic [1:0] es, input logic ed);
    out_ready = 1'b1;
    in_cmd    = cmd;
    in_valid  = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check({tag, "_level_push"}, 32'(level), 1);
    check({tag, "_valid_n1"}, 32'(out_valid), 0);
    tick();
    check({tag, "_valid_n1b"}, 32'(out_valid), 0);
    check({tag, "_alu_a"}, 32'(alu_a), 32'(cmd[2:0]));
    check({tag, "_alu_b"}, 32'(alu_b), 32'(cmd[5:3]));
    check({tag, "_alu_sel"}, 32'(alu_sel), 32'(cmd[7:6]));
    tick();
    check({tag, "_valid_n2"}, 32'(out_valid), 1);
    check({tag, "_result"}, 32'(out_result), 32'(er));
    check({tag, "_sel"}, 32'(out_sel), 32'(es));
    check({tag, "_dz"}, 32'(out_dz), 32'(ed));
    check({tag, "_level_pop"}, 32'(level), 0);
    tick();
    check({tag, "_valid_done"}, 32'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_cmd    = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_level", 32'(level), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_alu", 32'({alu_a, alu_b, alu_sel}), 0);
    check("rst_out", 32'({out_result, out_sel, out_dz}), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Push in the first cycle after reset, then a few single operations.
    single("add", 8'h1D, 6'd8, 2'd0, 1'b0);
    single("div0", 8'hC6, 6'h3F, 2'd3, 1'b1);
    single("sub", 8'h6A, 6'h3D, 2'd1, 1'b0);
    single("div", 8'hD7, 6'd3, 2'd3, 1'b0);

    // Fill: one result held plus four queued, then the next push is refused.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_cmd   = fc[i];
      in_valid = 1'b1;
      check("fill_in_ready", 32'(in_ready), 1);
      tick();
    end
    in_cmd = 8'h00;
    check("full_in_ready", 32'(in_ready), 0);
    check("full_level", 32'(level), 4);
    check("full_valid", 32'(out_valid), 1);
    check("full_result0", 32'(out_result), 32'(fr[0]));
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_level", 32'(level), 4);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_payload", 32'({out_result, out_sel, out_dz}), 32'({fr[0], fs[0], fd[0]}));
      check("bp_in_ready", 32'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      check("drain_gap", 32'(out_valid), 0);
      check("drain_alu", 32'({alu_sel, alu_b, alu_a}), 32'(fc[k]));
      tick();
      check("drain_valid", 32'(out_valid), 1);
      check("drain_result", 32'(out_result), 32'(fr[k]));
      check("drain_sel", 32'(out_sel), 32'(fs[k]));
      check("drain_dz", 32'(out_dz), 32'(fd[k]));
      check("drain_alu_hold", 32'({alu_sel, alu_b, alu_a}), 32'(fc[k]));
      check("drain_level", 32'(level), 32'(4 - k));
    end
    tick();
    check("drain_end_valid", 32'(out_valid), 0);
    check("drain_end_level", 32'(level), 0);

    // Reset while in SETTLE with three entries queued.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_cmd   = fc[i];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("mid_level", 32'(level), 3);
    check("mid_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    check("mid_settle_valid", 32'(out_valid), 0);
    check("mid_settle_level", 32'(level), 3);
    check("mid_settle_alu", 32'({alu_sel, alu_b, alu_a}), 32'(fc[1]));
    rst = 1'b1;
    tick();
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_alu", 32'({alu_a, alu_b, alu_sel}), 0);
    check("mid_rst_out", 32'({out_result, out_sel, out_dz}), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    single("mul_after_rst", 8'h9F, 6'd21, 2'd2, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("no_stale_valid", 32'(out_valid), 0);
      check("no_stale_level", 32'(level), 0);
    end

    // Eight commands back to back: pointers wrap twice.
    out_ready = 1'b1;
    idx  = 0;
    ridx = 0;
    for (int cyc = 0; cyc < 200 && ridx < 8; cyc++) begin
      if (idx < 8) begin
        in_cmd   = wc[idx];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
      if (out_valid) begin
        check("wrap_result", 32'(out_result), 32'(wr[ridx]));
        check("wrap_sel", 32'(out_sel), 32'(ws[ridx]));
        ridx++;
      end
    end
    in_valid = 1'b0;
    check("wrap_pushed", 32'(idx), 8);
    check("wrap_results", 32'(ridx), 8);
    tick();
    check("wrap_end_level", 32'(level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
